// File: rtl/cordic_vectoring_core_if.sv
// Stream interface for the CORDIC vectoring core.
// Carries the Cartesian sample in and the polar result out, each with a valid/ready handshake.
interface cordic_vectoring_core_if #(
    parameter int XY_W    = 16,
    parameter int ANGLE_W = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [XY_W-1:0]    x_start;
    logic signed [XY_W-1:0]    y_start;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [XY_W-1:0]    mag;
    logic signed [ANGLE_W-1:0] theta;

    modport master (
        output in_valid, x_start, y_start, out_ready,
        input  in_ready, out_valid, mag, theta
    );

    modport slave (
        input  in_valid, x_start, y_start, out_ready,
        output in_ready, out_valid, mag, theta
    );
endinterface

// File: rtl/cordic_vectoring_core.sv
// Iterative CORDIC in vectoring mode: converts one (x, y) sample into magnitude and atan2 angle.
// The angle is a signed fraction of a full turn (2^ANGLE_W per turn) and wraps modulo 2^ANGLE_W.
// The angle table is held at 32-bit turn resolution and rounded down to ANGLE_W, so ANGLE_W <= 32.
module cordic_vectoring_core #(
    parameter int XY_W      = 16,
    parameter int ANGLE_W   = 32,
    parameter int ITER      = 16,
    parameter int GUARD     = 3,
    parameter int GAIN_COMP = 1
) (
    input logic                     clk,
    input logic                     rst,
    cordic_vectoring_core_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W   = XY_W + GUARD + 2;
    localparam int PW  = W + 18;
    localparam int CW  = $clog2(ITER + 2);
    localparam int ASH = 32 - ANGLE_W;

    localparam logic [CW-1:0]         ROT_END    = CW'(ITER);
    localparam logic [CW-1:0]         ROUND_STEP = CW'(ITER + 1);
    localparam logic [ANGLE_W-1:0]    HALF_TURN  = {1'b1, {(ANGLE_W-1){1'b0}}};
    localparam logic signed [PW-1:0]  COMP_C     = PW'(39797);
    localparam logic signed [PW-1:0]  MAG_MAX    = PW'((1 <<< (XY_W-1)) - 1);

    state_t state_q, state_n;

    logic signed [W-1:0]    x_q, y_q;
    logic [ANGLE_W-1:0]     z_q;
    logic [CW-1:0]          cnt_q;
    logic signed [PW-1:0]   comp_q;
    logic                   zero_q;
    logic [XY_W-1:0]        mag_q;
    logic [ANGLE_W-1:0]     theta_q;

    logic                   accept;
    logic signed [W-1:0]    x_ext, y_ext, x_shr, y_shr;
    logic [ANGLE_W-1:0]     a_i;
    logic signed [PW-1:0]   comp_n, scaled, round_sum, rounded;
    logic [XY_W-1:0]        mag_n;

    // atan(2^-i) in turns, 32-bit resolution, rounded to ANGLE_W bits
    function automatic logic [ANGLE_W-1:0] atan_step(input int i);
        logic [31:0] t;
        logic [33:0] s;
        case (i)
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2FA;
            15: t = 32'h0000_517D;
            16: t = 32'h0000_28BE;
            17: t = 32'h0000_145F;
            18: t = 32'h0000_0A30;
            19: t = 32'h0000_0518;
            20: t = 32'h0000_028C;
            21: t = 32'h0000_0146;
            22: t = 32'h0000_00A3;
            23: t = 32'h0000_0051;
            24: t = 32'h0000_0029;
            25: t = 32'h0000_0014;
            26: t = 32'h0000_000A;
            27: t = 32'h0000_0005;
            28: t = 32'h0000_0003;
            29: t = 32'h0000_0001;
            30: t = 32'h0000_0001;
            default: t = 32'h0000_0000;
        endcase
        s = ({2'b00, t} << 1) + (34'd1 << ASH);
        return ANGLE_W'(s >> (ASH + 1));
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state: accept in IDLE, leave RUN after the rounding step, return on output handshake
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_n = RUN;
            RUN:     if (cnt_q == ROUND_STEP) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so no combinational path crosses the block
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Pre-rotation operands, micro-rotation shifts, gain compensation and rounding/saturation
    always_comb begin
        accept    = (state_q == IDLE) && bus.in_valid;
        x_ext     = {{(W-XY_W){bus.x_start[XY_W-1]}}, bus.x_start} <<< GUARD;
        y_ext     = {{(W-XY_W){bus.y_start[XY_W-1]}}, bus.y_start} <<< GUARD;
        x_shr     = x_q >>> cnt_q;
        y_shr     = y_q >>> cnt_q;
        a_i       = atan_step(int'(cnt_q));
        comp_n    = (GAIN_COMP != 0) ? PW'(x_q) * COMP_C : PW'(x_q) <<< 16;
        scaled    = comp_q >>> 16;
        round_sum = (scaled <<< 1) + (PW'(1) <<< GUARD);
        rounded   = round_sum >>> (GUARD + 1);
        if (rounded < 0)             mag_n = '0;
        else if (rounded > MAG_MAX)  mag_n = XY_W'(MAG_MAX);
        else                         mag_n = XY_W'(rounded);
    end

    // Datapath: load on accept, rotate ITER times, register the gain product, then round into the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            comp_q  <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            theta_q <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            zero_q <= (bus.x_start == '0) && (bus.y_start == '0);
            if (bus.x_start[XY_W-1]) begin
                x_q <= -x_ext;
                y_q <= -y_ext;
                z_q <= HALF_TURN;
            end else begin
                x_q <= x_ext;
                y_q <= y_ext;
                z_q <= '0;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q < ROT_END) begin
                if (!y_q[W-1]) begin
                    x_q <= x_q + y_shr;
                    y_q <= y_q - x_shr;
                    z_q <= z_q + a_i;
                end else begin
                    x_q <= x_q - y_shr;
                    y_q <= y_q + x_shr;
                    z_q <= z_q - a_i;
                end
            end else if (cnt_q == ROT_END) begin
                comp_q <= comp_n;
            end else begin
                mag_q   <= zero_q ? '0 : mag_n;
                theta_q <= zero_q ? '0 : z_q;
            end
        end
    end

    assign bus.mag   = mag_q;
    assign bus.theta = theta_q;

endmodule

// File: tb/tb_cordic_vectoring_core.sv
// Self-checking bench for cordic_vectoring_core: scoreboard of expected polar results
// computed with real math, random output stalls, handshake timing, reset abort and an
// uncompensated-gain instance.
module tb_cordic_vectoring_core;

    localparam real    PI        = 3.14159265358979323846;
    localparam real    TURN      = 4294967296.0;
    localparam real    K_GAIN    = 1.646760258;
    localparam longint THETA_TOL = 68356;
    localparam longint MAG_TOL   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;

    longint exp_mag_q[$];
    longint exp_theta_q[$];
    longint exp_tol_q[$];
    string  exp_tag_q[$];

    longint mon_mag, mon_theta, mon_tol;
    string  mon_tag;

    cordic_vectoring_core_if #(.XY_W(16), .ANGLE_W(32)) bus ();
    cordic_vectoring_core_if #(.XY_W(16), .ANGLE_W(32)) bus0 ();

    cordic_vectoring_core #(.GAIN_COMP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cordic_vectoring_core #(.GAIN_COMP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Counts one comparison and reports it when |observed - expected| exceeds tol
    task automatic checkOutput(input string tag, input longint observed, input longint expected,
                               input longint tol, input bit wrap);
        longint diff;
        diff = observed - expected;
        if (wrap) diff = longint'($signed(diff[31:0]));
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    function automatic longint expTheta(input int x, input int y);
        real a;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x));
        return longint'(a / (2.0 * PI) * TURN);
    endfunction

    function automatic longint expMag(input int x, input int y, input bit comp);
        real    h;
        longint r;
        h = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (!comp) h = h * K_GAIN;
        r = longint'(h);
        if (r > 32767) r = 32767;
        return r;
    endfunction

    // out_ready driver: random 75% high, held low, or held high
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: a result is consumed on the edge after out_valid && out_ready is seen
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_mag_q.size() == 0) begin
                checkOutput("spurious_out", longint'(bus.out_valid), 0, 0, 1'b0);
            end else begin
                mon_mag   = exp_mag_q.pop_front();
                mon_theta = exp_theta_q.pop_front();
                mon_tol   = exp_tol_q.pop_front();
                mon_tag   = exp_tag_q.pop_front();
                checkOutput({mon_tag, "_mag"}, longint'(bus.mag), mon_mag, mon_tol, 1'b0);
                checkOutput({mon_tag, "_theta"}, longint'(bus.theta), mon_theta, THETA_TOL, 1'b1);
            end
        end
    end

    task automatic pushExpected(input string tag, input int x, input int y);
        longint m;
        m = expMag(x, y, 1'b1);
        exp_mag_q.push_back(m);
        exp_theta_q.push_back(expTheta(x, y));
        exp_tol_q.push_back((m == 32767 || m == 0) ? 0 : MAG_TOL);
        exp_tag_q.push_back(tag);
    endtask

    task automatic applyStimulus(input string tag, input int x, input int y);
        int n;
        @(posedge clk);
        #1;
        bus.x_start  = 16'(x);
        bus.y_start  = 16'(y);
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checkOutput({tag, "_accept"}, longint'(bus.in_ready), 1, 0, 1'b0);
            bus.in_valid = 1'b0;
            return;
        end
        pushExpected(tag, x, y);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_mag_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_mag_q.size() != 0)
            checkOutput("drain_timeout", longint'(exp_mag_q.size()), 0, 0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic runGc0(input string tag, input int x, input int y);
        int n;
        @(posedge clk);
        #1;
        bus0.x_start  = 16'(x);
        bus0.y_start  = 16'(y);
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus0.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, longint'(bus0.out_valid), 1, 0, 1'b0);
        checkOutput({tag, "_mag"}, longint'(bus0.mag), expMag(x, y, 1'b0), MAG_TOL, 1'b0);
        checkOutput({tag, "_theta"}, longint'(bus0.theta), expTheta(x, y), THETA_TOL, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Main sequence
    initial begin
        int lat;
        bus.in_valid   = 1'b0;
        bus.x_start    = '0;
        bus.y_start    = '0;
        bus0.in_valid  = 1'b0;
        bus0.x_start   = '0;
        bus0.y_start   = '0;
        bus0.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", longint'(bus.in_ready), 1, 0, 1'b0);
        checkOutput("rst_out_valid", longint'(bus.out_valid), 0, 0, 1'b0);
        checkOutput("rst_mag", longint'(bus.mag), 0, 0, 1'b0);
        checkOutput("rst_theta", longint'(bus.theta), 0, 0, 1'b0);
        rst = 1'b0;

        ready_mode = 0;
        applyStimulus("q1", 20000, 10000);
        applyStimulus("q2", -20000, 10000);
        applyStimulus("q3", -20000, -10000);
        applyStimulus("q4", 20000, -10000);
        applyStimulus("pos_y", 0, 20000);
        applyStimulus("neg_y", 0, -20000);
        applyStimulus("pos_x", 20000, 0);
        applyStimulus("neg_x", -20000, 0);
        applyStimulus("origin", 0, 0);
        applyStimulus("sat", -32768, -32768);
        waitDrain();

        $display("[TB] handshake timing and stall");
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        bus.x_start  = 16'(0);
        bus.y_start  = 16'(20000);
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("hs_idle_ready", longint'(bus.in_ready), 1, 0, 1'b0);
        pushExpected("hs", 0, 20000);
        @(posedge clk);
        #1;
        checkOutput("in_ready_drop", longint'(bus.in_ready), 0, 0, 1'b0);
        bus.x_start = 16'(1234);
        bus.y_start = -16'sd555;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", longint'(lat), 18, 0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", longint'(bus.out_valid), 1, 0, 1'b0);
            checkOutput("hold_in_ready", longint'(bus.in_ready), 0, 0, 1'b0);
            checkOutput("hold_mag", longint'(bus.mag), 20000, MAG_TOL, 1'b0);
            checkOutput("hold_theta", longint'(bus.theta), 64'h4000_0000, THETA_TOL, 1'b1);
        end
        bus.in_valid = 1'b0;
        ready_mode = 2;
        waitDrain();
        repeat (25) @(posedge clk);
        #1;
        checkOutput("no_second_accept", longint'(bus.out_valid), 0, 0, 1'b0);

        $display("[TB] reset during RUN");
        applyStimulus("abort", 20000, 10000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", longint'(bus.out_valid), 0, 0, 1'b0);
        checkOutput("abort_in_ready", longint'(bus.in_ready), 1, 0, 1'b0);
        exp_mag_q.delete();
        exp_theta_q.delete();
        exp_tol_q.delete();
        exp_tag_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("abort_no_output", longint'(bus.out_valid), 0, 0, 1'b0);
        applyStimulus("after_rst", -20000, 10000);
        waitDrain();

        $display("[TB] uncompensated gain");
        runGc0("gc0_sat", 20000, 0);
        runGc0("gc0_10k", 10000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck handshake still ends the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
